sc_nivel_ctrl: RTL and testbench

- Game-level sequencer for the vehicle lanes.
- Drives the shared level code and the level-load strobe into every vehicle-lane register block (the NVL/CN inputs of each lane).
- Tracks lives, advances the level when the frog reaches the goal, and reloads the lanes after a collision.
- Sits between the frog/collision logic and the lane blocks, and raises game-over/win flags for display.

---
 rtl/sc_nivel_ctrl_pkg.sv | 19 +
 rtl/sc_nivel_timer.sv | 26 ++
 rtl/sc_nivel_ctrl.sv | 105 ++++++++++
 tb/tb_sc_nivel_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sc_nivel_ctrl_pkg.sv
// Shared types and defaults for the lane level sequencer.
package sc_nivel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam int NVL_DW_DEF     = 2;
    localparam int LIVES_DW_DEF   = 2;
    localparam int LIVES_INIT_DEF = 3;
    localparam int PAUSE_DW_DEF   = 4;
    localparam int NVL_MAX        = (1 << NVL_DW_DEF) - 1;

endpackage

// File: rtl/sc_nivel_timer.sv
// Clear/enable up-counter; tc flags the all-ones count.
module sc_nivel_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/sc_nivel_ctrl.sv
// Game-level sequencer: level code, lane load strobe, lives and
// game-over/win flags for the vehicle lanes.
module sc_nivel_ctrl
    import sc_nivel_ctrl_pkg::*;
#(
    parameter int DATAWIDTH_NVL   = NVL_DW_DEF,
    parameter int DATAWIDTH_LIVES = LIVES_DW_DEF,
    parameter int LIVES_INIT      = LIVES_INIT_DEF,
    parameter int PAUSE_DATAWIDTH = PAUSE_DW_DEF
) (
    input  logic                       SC_NIVEL_CTRL_CLOCK,
    input  logic                       SC_NIVEL_CTRL_RESET,
    input  logic                       SC_NIVEL_CTRL_START_IN,
    input  logic                       SC_NIVEL_CTRL_GOAL_IN,
    input  logic                       SC_NIVEL_CTRL_HIT_IN,
    output logic [DATAWIDTH_NVL-1:0]   SC_NIVEL_CTRL_NVL_OUT,
    output logic                       SC_NIVEL_CTRL_CN_OUT,
    output logic [DATAWIDTH_LIVES-1:0] SC_NIVEL_CTRL_LIVES_OUT,
    output logic                       SC_NIVEL_CTRL_RUN_OUT,
    output logic                       SC_NIVEL_CTRL_GAMEOVER_OUT,
    output logic                       SC_NIVEL_CTRL_WIN_OUT
);

    localparam logic [DATAWIDTH_NVL-1:0] NVL_TOP = '1;
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_RST =
        DATAWIDTH_LIVES'(LIVES_INIT);
    localparam logic [DATAWIDTH_LIVES-1:0] LIVES_ONE =
        DATAWIDTH_LIVES'(1);

    state_t                     state, state_nx;
    logic [DATAWIDTH_NVL-1:0]   nvl, nvl_nx;
    logic [DATAWIDTH_LIVES-1:0] lives, lives_nx;
    logic                       pause_tc;

    // Counter is held clear outside PAUSE, so each PAUSE starts at zero.
    sc_nivel_timer #(
        .W (PAUSE_DATAWIDTH)
    ) u_timer (
        .clk (SC_NIVEL_CTRL_CLOCK),
        .rst (SC_NIVEL_CTRL_RESET),
        .clr (state != ST_PAUSE),
        .en  (state == ST_PAUSE),
        .tc  (pause_tc)
    );

    always_comb begin
        state_nx = state;
        nvl_nx   = nvl;
        lives_nx = lives;
        unique case (state)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (SC_NIVEL_CTRL_START_IN) begin
                    state_nx = ST_LOAD;
                    nvl_nx   = '0;
                    lives_nx = LIVES_RST;
                end
            end
            ST_LOAD: state_nx = ST_RUN;
            ST_RUN: begin
                if (SC_NIVEL_CTRL_HIT_IN) begin
                    if (lives > LIVES_ONE) begin
                        lives_nx = lives - 1'b1;
                        state_nx = ST_PAUSE;
                    end else begin
                        if (lives != '0) lives_nx = lives - 1'b1;
                        state_nx = ST_OVER;
                    end
                end else if (SC_NIVEL_CTRL_GOAL_IN) begin
                    if (nvl != NVL_TOP) begin
                        nvl_nx   = nvl + 1'b1;
                        state_nx = ST_PAUSE;
                    end else begin
                        state_nx = ST_WIN;
                    end
                end
            end
            ST_PAUSE: if (pause_tc) state_nx = ST_LOAD;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_NIVEL_CTRL_CLOCK or posedge SC_NIVEL_CTRL_RESET) begin
        if (SC_NIVEL_CTRL_RESET) begin
            state                      <= ST_IDLE;
            nvl                        <= '0;
            lives                      <= LIVES_RST;
            SC_NIVEL_CTRL_CN_OUT       <= 1'b0;
            SC_NIVEL_CTRL_RUN_OUT      <= 1'b0;
            SC_NIVEL_CTRL_GAMEOVER_OUT <= 1'b0;
            SC_NIVEL_CTRL_WIN_OUT      <= 1'b0;
        end else begin
            state                      <= state_nx;
            nvl                        <= nvl_nx;
            lives                      <= lives_nx;
            SC_NIVEL_CTRL_CN_OUT       <= (state_nx == ST_LOAD);
            SC_NIVEL_CTRL_RUN_OUT      <= (state_nx == ST_RUN);
            SC_NIVEL_CTRL_GAMEOVER_OUT <= (state_nx == ST_OVER);
            SC_NIVEL_CTRL_WIN_OUT      <= (state_nx == ST_WIN);
        end
    end

    assign SC_NIVEL_CTRL_NVL_OUT   = nvl;
    assign SC_NIVEL_CTRL_LIVES_OUT = lives;

endmodule

// File: tb/tb_sc_nivel_ctrl.sv
// Table-driven bench for sc_nivel_ctrl with an expected-output queue.
module tb_sc_nivel_ctrl;

    typedef struct packed {
        logic [1:0] nvl;
        logic [1:0] lives;
        logic       cn;
        logic       run;
        logic       over;
        logic       win;
    } obs_t;

    typedef struct {
        logic s;
        logic g;
        logic h;
        int   n;
        obs_t exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       goal;
    logic       hit;
    logic [1:0] nvl_o;
    logic       cn_o;
    logic [1:0] lives_o;
    logic       run_o;
    logic       over_o;
    logic       win_o;

    int   total;
    int   bad;
    vec_t tbl[$];
    obs_t exp_q[$];

    sc_nivel_ctrl dut (
        .SC_NIVEL_CTRL_CLOCK        (clk),
        .SC_NIVEL_CTRL_RESET        (rst),
        .SC_NIVEL_CTRL_START_IN     (start),
        .SC_NIVEL_CTRL_GOAL_IN      (goal),
        .SC_NIVEL_CTRL_HIT_IN       (hit),
        .SC_NIVEL_CTRL_NVL_OUT      (nvl_o),
        .SC_NIVEL_CTRL_CN_OUT       (cn_o),
        .SC_NIVEL_CTRL_LIVES_OUT    (lives_o),
        .SC_NIVEL_CTRL_RUN_OUT      (run_o),
        .SC_NIVEL_CTRL_GAMEOVER_OUT (over_o),
        .SC_NIVEL_CTRL_WIN_OUT      (win_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic g, input logic h,
                       input int n, input int nv, input int lv,
                       input logic cn, input logic rn,
                       input logic ov, input logic wn);
        vec_t v;
        v.s   = s;
        v.g   = g;
        v.h   = h;
        v.n   = n;
        v.exp = '{nvl: 2'(nv), lives: 2'(lv), cn: cn,
                  run: rn, over: ov, win: wn};
        tbl.push_back(v);
    endtask

    // 16 PAUSE cycles total: the entry row plus these 15, then LOAD, RUN.
    task automatic pause_seq(input int nv, input int lv);
        add(0, 0, 0, 15, nv, lv, 0, 0, 0, 0);
        add(0, 0, 0, 1,  nv, lv, 1, 0, 0, 0);
        add(0, 0, 0, 1,  nv, lv, 0, 1, 0, 0);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{nvl: nvl_o, lives: lives_o, cn: cn_o,
              run: run_o, over: over_o, win: win_o};
        return o;
    endfunction

    task automatic chk(input string name, input int idx,
                       input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got nvl=%0d lives=%0d cn=%b run=%b over=%b win=%b want nvl=%0d lives=%0d cn=%b run=%b over=%b win=%b",
                     name, idx, got.nvl, got.lives, got.cn, got.run,
                     got.over, got.win, want.nvl, want.lives, want.cn,
                     want.run, want.over, want.win);
        end
    endtask

    obs_t rst_val;

    initial begin
        total   = 0;
        bad     = 0;
        rst_val = '{nvl: 2'd0, lives: 2'd3, cn: 1'b0,
                    run: 1'b0, over: 1'b0, win: 1'b0};
        rst   = 1'b1;
        start = 1'b0;
        goal  = 1'b0;
        hit   = 1'b0;

        // start at cycle 5, then four goals up to WIN
        add(0, 0, 0, 4, 0, 3, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
        add(0, 0, 0, 2, 0, 3, 0, 1, 0, 0);
        add(0, 1, 0, 1, 1, 3, 0, 0, 0, 0);
        pause_seq(1, 3);
        add(0, 1, 0, 1, 2, 3, 0, 0, 0, 0);
        pause_seq(2, 3);
        add(0, 1, 0, 1, 3, 3, 0, 0, 0, 0);
        pause_seq(3, 3);
        add(0, 1, 0, 1, 3, 3, 0, 0, 0, 1);
        add(0, 0, 0, 3, 3, 3, 0, 0, 0, 1);
        // restart, three hits to game over
        add(1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
        pause_seq(0, 2);
        add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        pause_seq(0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 3, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0, 1, 0, 0);
        // hit beats goal; goal/start ignored in PAUSE
        add(0, 1, 0, 1, 1, 3, 0, 0, 0, 0);
        pause_seq(1, 3);
        add(0, 1, 1, 1, 1, 2, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 2, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 13, 1, 2, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 2, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 2, 0, 1, 0, 0);
        // reach RUN at NVL=2, LIVES=1
        add(0, 1, 0, 1, 2, 2, 0, 0, 0, 0);
        pause_seq(2, 2);
        add(0, 0, 1, 1, 2, 1, 0, 0, 0, 0);
        pause_seq(2, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 0, sample(), rst_val);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rel", 0, sample(), rst_val);

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                @(negedge clk);
                start = tbl[r].s;
                goal  = tbl[r].g;
                hit   = tbl[r].h;
                exp_q.push_back(tbl[r].exp);
                @(posedge clk);
                #1;
                chk("vec", r, sample(), exp_q.pop_front());
            end
        end
        @(negedge clk);
        start = 1'b0;
        goal  = 1'b0;
        hit   = 1'b0;

        // asynchronous reset from RUN, away from any clock edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 0, sample(), rst_val);
        @(posedge clk);
        #1;
        chk("rst_edge", 0, sample(), rst_val);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst", k, sample(), rst_val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
